// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Optional same-cycle writeback bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

    localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: claims set, writebacks clear, set beats clear.
// With REGFILE_BYPASS_EN the WAW check sees this cycle's clears.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NWRITE = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_valid,
    input  logic [AW-1:0]                iss_rd,
    output logic                         iss_ready,
    input  logic [NWRITE-1:0]            wb_en,
    input  logic [NWRITE-1:0][AW-1:0]    wb_addr,
    output logic [NREGS-1:0]             pend_vec
);
    logic [NREGS-1:0] pend_q, pend_d, clr, set;

    always_comb begin
        clr = '0;
        set = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wb_en[j] && wb_addr[j] != AW'(ZERO_REG)) clr[wb_addr[j]] = 1'b1;
        end
`ifdef REGFILE_BYPASS_EN
        iss_ready = !(iss_rd != AW'(ZERO_REG) && pend_q[iss_rd] && !clr[iss_rd]);
`else
        iss_ready = !(iss_rd != AW'(ZERO_REG) && pend_q[iss_rd]);
`endif
        if (iss_valid && iss_ready && iss_rd != AW'(ZERO_REG)) set[iss_rd] = 1'b1;
        // New producer wins over the retiring one on the same register
        pend_d    = (pend_q & ~clr) | set;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign pend_vec = pend_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with combinational reads and a pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREAD-1:0][AW-1:0]       rd_addr,
    output logic [NREAD-1:0][XLEN-1:0]     rd_data,
    output logic [NREAD-1:0]               rd_pending,
    input  logic                           iss_valid,
    input  logic [AW-1:0]                  iss_rd,
    output logic                           iss_ready,
    input  logic [NWRITE-1:0]              wb_en,
    input  logic [NWRITE-1:0][AW-1:0]      wb_addr,
    input  logic [NWRITE-1:0][XLEN-1:0]    wb_data,
    output logic [NREGS-1:0]               pend_vec
);
    logic [XLEN-1:0] regs_q [NREGS];

    regfile_scoreboard #(.NREGS(NREGS), .NWRITE(NWRITE), .AW(AW)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .pend_vec  (pend_vec)
    );

    // Ascending port order makes the highest-indexed colliding writer win
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wb_en[j] && wb_addr[j] != AW'(ZERO_REG)) regs_q[wb_addr[j]] <= wb_data[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i]    = regs_q[rd_addr[i]];
            rd_pending[i] = pend_vec[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWRITE; j++) begin
                if (wb_en[j] && wb_addr[j] != AW'(ZERO_REG) && wb_addr[j] == rd_addr[i]) begin
                    rd_data[i]    = wb_data[j];
                    rd_pending[i] = 1'b0;
                end
            end
`endif
            if (rd_addr[i] == AW'(ZERO_REG)) begin
                rd_data[i]    = '0;
                rd_pending[i] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plan items plus randomized traffic checked against an array model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN = 32, NREGS = 32, NREAD = 2, NWRITE = 2, AW = 5;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NREAD-1:0][AW-1:0]     rd_addr;
    logic [NREAD-1:0][XLEN-1:0]   rd_data;
    logic [NREAD-1:0]             rd_pending;
    logic                         iss_valid;
    logic [AW-1:0]                iss_rd;
    logic                         iss_ready;
    logic [NWRITE-1:0]            wb_en;
    logic [NWRITE-1:0][AW-1:0]    wb_addr;
    logic [NWRITE-1:0][XLEN-1:0]  wb_data;
    logic [NREGS-1:0]             pend_vec;

    int n_chk  = 0;
    int n_fail = 0;

    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_pend;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREGS-1:0] m_clears();
        logic [NREGS-1:0] c = '0;
        for (int j = 0; j < NWRITE; j++)
            if (wb_en[j] && wb_addr[j] != 0) c[wb_addr[j]] = 1'b1;
        return c;
    endfunction

    function automatic logic m_ready();
        logic [NREGS-1:0] eff = m_pend;
`ifdef REGFILE_BYPASS_EN
        eff = eff & ~m_clears();
`endif
        return !(iss_rd != 0 && eff[iss_rd]);
    endfunction

    function automatic logic [XLEN-1:0] m_rdata(input int i);
        logic [XLEN-1:0] v = m_regs[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWRITE; j++)
            if (wb_en[j] && wb_addr[j] != 0 && wb_addr[j] == rd_addr[i]) v = wb_data[j];
`endif
        return (rd_addr[i] == 0) ? '0 : v;
    endfunction

    function automatic logic m_rpend(input int i);
        logic p = m_pend[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
        if (m_clears()[rd_addr[i]]) p = 1'b0;
`endif
        return (rd_addr[i] == 0) ? 1'b0 : p;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        m_pend = '0;
    endtask

    task automatic model_edge();
        logic [NREGS-1:0] c = m_clears();
        logic             claim = iss_valid && m_ready() && iss_rd != 0;
        for (int j = 0; j < NWRITE; j++)
            if (wb_en[j] && wb_addr[j] != 0) m_regs[wb_addr[j]] = wb_data[j];
        m_pend = m_pend & ~c;
        if (claim) m_pend[iss_rd] = 1'b1;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("rd_data[%0d]@%0d", i, rd_addr[i]), rd_data[i], m_rdata(i));
            chk($sformatf("rd_pending[%0d]@%0d", i, rd_addr[i]), 32'(rd_pending[i]), 32'(m_rpend(i)));
        end
        chk("iss_ready", 32'(iss_ready), 32'(m_ready()));
        chk("pend_vec", pend_vec, m_pend);
    endtask

    // Check the current cycle's outputs, then advance one edge
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_en     = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr(input bit narrow);
        return narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS-1));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = '0; iss_rd = '0; wb_addr = '0; wb_data = '0;
        model_reset();
        #12;
        for (int a = 0; a < NREGS; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(NREGS - 1 - a);
            #1;
            chk("rst_rd_data0", rd_data[0], 32'h0);
            chk("rst_rd_data1", rd_data[1], 32'h0);
            chk("rst_rd_pend", 32'(rd_pending), 32'h0);
        end
        chk("rst_iss_ready", 32'(iss_ready), 32'h1);
        chk("rst_pend_vec", pend_vec, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Claim r5, write it next cycle: pending for exactly one cycle
        iss_valid = 1'b1; iss_rd = 5;
        step();
        chk("pend5_set", 32'(pend_vec[5]), 32'h1);
        idle();
        wb_en = 2'b01; wb_addr[0] = 5; wb_data[0] = 32'hDEADBEEF; rd_addr[0] = 5;
        step();
        chk("pend5_clr", 32'(pend_vec[5]), 32'h0);
        idle();
        #1;
        chk("r5_data", rd_data[0], 32'hDEADBEEF);
        chk("r5_pend", 32'(rd_pending[0]), 32'h0);

        // WAW stall on r7, released by its writeback
        iss_valid = 1'b1; iss_rd = 7;
        step();
        #1;
        chk("r7_stall", 32'(iss_ready), 32'h0);
        step();
        idle();
        wb_en = 2'b10; wb_addr[1] = 7; wb_data[1] = 32'h77;
        step();
        idle();
        iss_valid = 1'b1; iss_rd = 7;
        #1;
        chk("r7_ready", 32'(iss_ready), 32'h1);
        step();
        chk("r7_reclaim", 32'(pend_vec[7]), 32'h1);
        // Writeback and claim of pending r7 in one cycle
        wb_en = 2'b01; wb_addr[0] = 7; wb_data[0] = 32'h78;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r7_wb_claim_ready", 32'(iss_ready), 32'h1);
        step();
        chk("r7_wb_claim_pend", 32'(pend_vec[7]), 32'h1);
`else
        chk("r7_wb_claim_ready", 32'(iss_ready), 32'h0);
        step();
        chk("r7_wb_claim_pend", 32'(pend_vec[7]), 32'h0);
`endif
        idle();

        // Same-address collision: port 1 wins
        wb_en = 2'b11; wb_addr[0] = 3; wb_addr[1] = 3; wb_data[0] = 32'h11; wb_data[1] = 32'h22;
        step();
        idle();
        rd_addr[1] = 3;
        #1;
        chk("r3_collision", rd_data[1], 32'h22);

        // r0 is hardwired
        wb_en = 2'b01; wb_addr[0] = 0; wb_data[0] = 32'h1234;
        iss_valid = 1'b1; iss_rd = 0; rd_addr[0] = 0;
        #1;
        chk("r0_ready", 32'(iss_ready), 32'h1);
        step();
        chk("r0_pend", 32'(pend_vec[0]), 32'h0);
        chk("r0_data", rd_data[0], 32'h0);
        idle();

        // Same-cycle write/read of pending r9
        iss_valid = 1'b1; iss_rd = 9;
        step();
        idle();
        wb_en = 2'b01; wb_addr[0] = 9; wb_data[0] = 32'hCAFE; rd_addr[0] = 9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r9_bypass_data", rd_data[0], 32'hCAFE);
        chk("r9_bypass_pend", 32'(rd_pending[0]), 32'h0);
`else
        chk("r9_nobypass_data", rd_data[0], 32'h0);
        chk("r9_nobypass_pend", 32'(rd_pending[0]), 32'h1);
`endif
        step();
        idle();
        #1;
        chk("r9_after", rd_data[0], 32'hCAFE);

        for (int n = 0; n < 400; n++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            iss_valid = 1'($urandom);
            iss_rd    = rnd_addr(narrow);
            wb_en     = NWRITE'($urandom);
            for (int j = 0; j < NWRITE; j++) begin
                wb_addr[j] = rnd_addr(narrow);
                wb_data[j] = $urandom;
            end
            for (int i = 0; i < NREAD; i++) rd_addr[i] = rnd_addr(narrow);
            step();
        end

        // Asynchronous reset in the middle of a claim
        idle();
        iss_valid = 1'b1; iss_rd = 12;
        step();
        iss_rd = 13;
        wb_en = 2'b01; wb_addr[0] = 3; wb_data[0] = 32'h55;
        step();
        iss_rd = 14; rd_addr[0] = 12; rd_addr[1] = 3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_pend_vec", pend_vec, 32'h0);
        chk("arst_rd_data0", rd_data[0], 32'h0);
        chk("arst_rd_data1", rd_data[1], 32'h0);
        chk("arst_rd_pend", 32'(rd_pending), 32'h0);
        chk("arst_iss_ready", 32'(iss_ready), 32'h1);
        model_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            iss_valid = 1'($urandom);
            iss_rd    = rnd_addr(1'b1);
            wb_en     = NWRITE'($urandom);
            for (int j = 0; j < NWRITE; j++) begin
                wb_addr[j] = rnd_addr(1'b1);
                wb_data[j] = $urandom;
            end
            for (int i = 0; i < NREAD; i++) rd_addr[i] = rnd_addr(1'b1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with a per-register pending scoreboard, the pipelined successor to the single-write, dual-read register file. It sits between decode/issue and writeback in the core. It provides combinational reads on NREAD ports and synchronous writes on NWRITE ports. It also tracks which destination registers have an in-flight producer, so issue logic can detect RAW hazards and WAW stalls without a separate scoreboard.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- NREAD, 2, number of read ports
- NWRITE, 2, number of write (writeback) ports
- AW, $clog2(NREGS), derived register index width; not overridden

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NREAD×AW  read addresses
- rd_data  out  NREAD×XLEN  read data
- rd_pending  out  NREAD  addressed register has an outstanding producer
- iss_valid  in  1  issue request that claims destination iss_rd
- iss_rd  in  AW  destination being claimed
- iss_ready  out  1  the claim is accepted this cycle
- wb_en  in  NWRITE  write enables
- wb_addr  in  NWRITE×AW  write addresses
- wb_data  in  NWRITE×XLEN  write data
- pend_vec  out  NREGS  raw scoreboard, for debug and perf counters

## Operation
- State:
  - regs[NREGS] of XLEN bits
  - pend[NREGS] of 1 bit each
  - Register 0 is hardwired: it reads 0, is never pending, and writes to it are dropped.
- Reads:
  - rd_data[i] = regs[rd_addr[i]], or 0 when the address is 0.
  - rd_pending[i] = pend[rd_addr[i]], or 0 when the address is 0.
  - Reads are purely combinational.
- Writes:
  - On each edge, every port with wb_en[j]=1 and wb_addr[j]≠0 writes wb_data[j].
  - Same-address collision: the highest port index wins and lower ports are dropped silently.
  - A write to a register that is not pending is legal and updates the data. pend is unchanged.
- Scoreboard:
  - iss_ready = 1 unless (iss_rd≠0 and pend[iss_rd]=1). In that case a WAW stall is required.
  - iss_ready is valid whether or not iss_valid is asserted.
  - An accepted claim (iss_valid & iss_ready & iss_rd≠0) sets pend[iss_rd] at the edge.
  - Any write to address r clears pend[r] at the edge.
- Simultaneous events on the same register r in one cycle:
  - Writeback and accepted claim: the set wins, and pend[r]=1 after the edge. The older producer retires and the new one is in flight.
  - Claim while pend[r]=1 and writeback to r in the same cycle: iss_ready=0 in the base build, because the claim is evaluated against the registered pend.
- Reset: asserting rst at any time clears all regs and pend to 0 asynchronously. In-flight claims are lost.

## Timing
- Read latency is 0 cycles (combinational). Write and scoreboard latency is 1 edge.
- Outputs during and after reset:
  - rd_data = 0
  - rd_pending = 0
  - pend_vec = 0
  - iss_ready = 1
- Without bypass, data written at edge N is visible on rd_data from edge N onward, not in the same cycle as wb_en.
- There is no backpressure on writeback: wb_en is always accepted.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port whose address matches an active nonzero write port in the same cycle returns that wb_data, using the highest matching port. Its rd_pending reads 0.
  - In that cycle, iss_ready for iss_rd is computed against pend with that cycle's writeback clears already applied.
- REGFILE_BYPASS_EN undefined:
  - Reads and pending flags reflect registered state only, as described above.

## Structure
- Shared package regfile_pkg:
  - default XLEN/NREGS
  - typedef reg_idx_t (AW bits)
  - typedef xdata_t (XLEN bits)
  - constant ZERO_REG = 0
- One sub-module, regfile_scoreboard, holds pend, iss_ready, and the set/clear priority. The data array and read muxes stay in regfile_sb.

## Test plan
- Reset, then read all addresses -> rd_data=0 and rd_pending=0 everywhere; iss_ready=1.
- Claim r5, then write 0xDEADBEEF to r5 on the next cycle -> pend_vec[5] is 1 for exactly one cycle. After the write, reading r5 returns 0xDEADBEEF with rd_pending=0.
- With r7 pending, issue r7 -> iss_ready=0. After writeback of r7, iss_ready=1 and the claim sets pend again.
- Ports 0 and 1 both write r3, with 0x11 and 0x22 -> r3 reads 0x22.
- Write 0x1234 to r0 and claim r0 -> r0 reads 0, pend_vec[0]=0, iss_ready=1.
- With bypass enabled, write 0xCAFE to r9 with rd_addr[0]=9 in the same cycle -> rd_data[0]=0xCAFE and rd_pending[0]=0. Assert rst mid-claim -> everything clears immediately.
